// File: rtl/exp_series_ctrl.sv
// Moore sequencer for the Taylor-series exp datapath: INIT, alternating ADD/MUL terms, DONE.
// Optional synchronous cancel port is enabled by defining EXP_CTRL_ABORT_EN.
module exp_series_ctrl #(
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef EXP_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             ldX,
    output logic             ldTmp,
    output logic             selTmp,
    output logic             clrAcc,
    output logic             ldAcc,
    output logic [CNT_W-1:0] coefAddr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ADD  = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ldX      = 1'b0;
        ldTmp    = 1'b0;
        selTmp   = 1'b0;
        clrAcc   = 1'b0;
        ldAcc    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        coefAddr = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                ldX     = 1'b1;
                ldTmp   = 1'b1;
                clrAcc  = 1'b1;
                busy    = 1'b1;
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                ldAcc = 1'b1;
                busy  = 1'b1;
                // The last term finishes here, so MUL is skipped and cnt holds.
                if (cnt_q == LAST_TERM) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                ldTmp   = 1'b1;
                selTmp  = 1'b1;
                busy    = 1'b1;
                state_d = S_ADD;
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                coefAddr = '0;
                cnt_d    = '0;
                state_d  = S_IDLE;
            end
        endcase

`ifdef EXP_CTRL_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
`endif
    end

endmodule

// File: tb/tb_exp_series_ctrl.sv
// Directed bench for exp_series_ctrl: an N_TERMS=8 and an N_TERMS=1 instance,
// cycle-exact output traces with hand-derived expected vectors.
module tb_exp_series_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start8, start1;
    logic abort;

    logic       ldX8, ldTmp8, selTmp8, clrAcc8, ldAcc8, busy8, done8;
    logic [3:0] coef8;
    logic       ldX1, ldTmp1, selTmp1, clrAcc1, ldAcc1, busy1, done1;
    logic [3:0] coef1;

    int checks = 0;
    int errors = 0;

    // Output vector layout: {ldX, ldTmp, selTmp, clrAcc, ldAcc, busy, done, coefAddr}
    logic [10:0] obs8, obs1;
    assign obs8 = {ldX8, ldTmp8, selTmp8, clrAcc8, ldAcc8, busy8, done8, coef8};
    assign obs1 = {ldX1, ldTmp1, selTmp1, clrAcc1, ldAcc1, busy1, done1, coef1};

    always #5 clk = ~clk;

    exp_series_ctrl #(.N_TERMS(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
`ifdef EXP_CTRL_ABORT_EN
        .abort(abort),
`endif
        .ldX(ldX8), .ldTmp(ldTmp8), .selTmp(selTmp8), .clrAcc(clrAcc8),
        .ldAcc(ldAcc8), .coefAddr(coef8), .busy(busy8), .done(done8)
    );

    exp_series_ctrl #(.N_TERMS(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
`ifdef EXP_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .ldX(ldX1), .ldTmp(ldTmp1), .selTmp(selTmp1), .clrAcc(clrAcc1),
        .ldAcc(ldAcc1), .coefAddr(coef1), .busy(busy1), .done(done1)
    );

    localparam int K_IDLE = 0, K_INIT = 1, K_ADD = 2, K_MUL = 3, K_DONE = 4;

    // Expected outputs for a given state and counter value, from the state table.
    function automatic logic [10:0] exp_vec(input int kind, input int c);
        logic [6:0] s;
        case (kind)
            K_INIT:  s = 7'b1101010;
            K_ADD:   s = 7'b0000110;
            K_MUL:   s = 7'b0110010;
            K_DONE:  s = 7'b0000001;
            default: s = 7'b0000000;
        endcase
        return {s, 4'(c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0; abort = 1'b0;
        tick(); tick();
        checks++;
        if (obs8 !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_n8 actual=%b required=%b", obs8, 11'd0);
        end
        checks++;
        if (obs1 !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_n1 actual=%b required=%b", obs1, 11'd0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs8 !== exp_vec(K_IDLE, 0)) begin
            errors++;
            $display("[TB] FAIL idle_after_reset actual=%b required=%b", obs8, exp_vec(K_IDLE, 0));
        end
    endtask

    // mode 0: one-cycle start pulse, 1: start toggled while busy, 2: start held through DONE
    task automatic test_run8(input int mode, input string name);
        int n_acc = 0;
        int n_tmp = 0;
        logic [10:0] e;
        start8 = 1'b1;
        tick();
        for (int cyc = 0; cyc <= 16; cyc++) begin
            if (cyc == 0)            e = exp_vec(K_INIT, 0);
            else if (cyc == 16)      e = exp_vec(K_DONE, 7);
            else if (cyc % 2 == 1)   e = exp_vec(K_ADD, (cyc - 1) / 2);
            else                     e = exp_vec(K_MUL, cyc / 2);
            checks++;
            if (obs8 !== e) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d actual=%b required=%b", name, cyc, obs8, e);
            end
            if (ldAcc8 === 1'b1) n_acc++;
            if (ldTmp8 === 1'b1) n_tmp++;
            case (mode)
                1:       start8 = (cyc < 15) ? ((cyc % 3) != 0) : 1'b0;
                2:       start8 = 1'b1;
                default: start8 = 1'b0;
            endcase
            if (cyc < 16) tick();
        end
        checks++;
        if (n_acc != 8) begin
            errors++;
            $display("[TB] FAIL %s ldAcc_count actual=%0d required=8", name, n_acc);
        end
        checks++;
        if (n_tmp != 8) begin
            errors++;
            $display("[TB] FAIL %s ldTmp_count actual=%0d required=8", name, n_tmp);
        end
        if (mode == 2) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++;
                if (obs8 !== exp_vec(K_DONE, 7)) begin
                    errors++;
                    $display("[TB] FAIL %s hold_done %0d actual=%b required=%b", name, i, obs8, exp_vec(K_DONE, 7));
                end
            end
            start8 = 1'b0;
        end
        tick();
        checks++;
        if (obs8 !== exp_vec(K_IDLE, 0)) begin
            errors++;
            $display("[TB] FAIL %s back_to_idle actual=%b required=%b", name, obs8, exp_vec(K_IDLE, 0));
        end
    endtask

    task automatic test_reset_mid_run();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        checks++;
        if (obs8 !== exp_vec(K_MUL, 1)) begin
            errors++;
            $display("[TB] FAIL midrun_in_mul actual=%b required=%b", obs8, exp_vec(K_MUL, 1));
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs8 !== 11'd0) begin
            errors++;
            $display("[TB] FAIL midrun_async_reset actual=%b required=%b", obs8, 11'd0);
        end
        tick();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (obs8 !== exp_vec(K_IDLE, 0)) begin
            errors++;
            $display("[TB] FAIL midrun_idle_after_release actual=%b required=%b", obs8, exp_vec(K_IDLE, 0));
        end
    endtask

    task automatic test_single_term();
        logic [10:0] e [0:3];
        int n_acc = 0;
        e[0] = exp_vec(K_INIT, 0);
        e[1] = exp_vec(K_ADD, 0);
        e[2] = exp_vec(K_DONE, 0);
        e[3] = exp_vec(K_IDLE, 0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            checks++;
            if (obs1 !== e[cyc]) begin
                errors++;
                $display("[TB] FAIL single_term cycle %0d actual=%b required=%b", cyc, obs1, e[cyc]);
            end
            if (ldAcc1 === 1'b1) n_acc++;
            if (cyc < 3) tick();
        end
        checks++;
        if (n_acc != 1) begin
            errors++;
            $display("[TB] FAIL single_term ldAcc_count actual=%0d required=1", n_acc);
        end
    endtask

`ifdef EXP_CTRL_ABORT_EN
    task automatic test_abort();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (obs8 !== exp_vec(K_MUL, 3)) begin
            errors++;
            $display("[TB] FAIL abort_in_mul3 actual=%b required=%b", obs8, exp_vec(K_MUL, 3));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs8 !== exp_vec(K_IDLE, 0)) begin
                errors++;
                $display("[TB] FAIL abort_idle %0d actual=%b required=%b", i, obs8, exp_vec(K_IDLE, 0));
            end
            tick();
        end
        test_run8(0, "abort_restart");
    endtask
`endif

    initial begin
        test_reset();
        test_run8(0, "pulse");
        test_run8(2, "hold");
        test_run8(1, "toggle");
        test_reset_mid_run();
        test_single_term();
`ifdef EXP_CTRL_ABORT_EN
        test_abort();
`endif
        test_run8(0, "back_to_back");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
